// File: rtl/sync_fifo_prog_if.sv
// Bundle of the FIFO's request, threshold and status signals.
// The master side (producer/consumer) drives requests; the FIFO is the slave.
interface sync_fifo_prog_if #(
    parameter int F_WIDTH     = 8,
    parameter int F_PTR_WIDTH = 4
);
    logic                   clr;
    logic                   w_en;
    logic                   r_en;
    logic [F_WIDTH-1:0]     d_in;
    logic [F_PTR_WIDTH:0]   af_thresh;
    logic [F_PTR_WIDTH:0]   ae_thresh;

    logic [F_WIDTH-1:0]     d_out;
    logic                   d_valid;
    logic [F_PTR_WIDTH:0]   f_count;
    logic                   f_full_flag;
    logic                   f_empty_flag;
    logic                   f_half_full_flag;
    logic                   f_almost_full_flag;
    logic                   f_almost_empty_flag;
    logic                   f_overflow;
    logic                   f_underflow;

    modport master (
        output clr, w_en, r_en, d_in, af_thresh, ae_thresh,
        input  d_out, d_valid, f_count, f_full_flag, f_empty_flag,
               f_half_full_flag, f_almost_full_flag, f_almost_empty_flag,
               f_overflow, f_underflow
    );

    modport slave (
        input  clr, w_en, r_en, d_in, af_thresh, ae_thresh,
        output d_out, d_valid, f_count, f_full_flag, f_empty_flag,
               f_half_full_flag, f_almost_full_flag, f_almost_empty_flag,
               f_overflow, f_underflow
    );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost flags, flush,
// sticky overflow/underflow and optional first-word-fall-through output.
module sync_fifo_prog #(
    parameter int F_WIDTH     = 8,
    parameter int F_DEPTH     = 16,
    parameter int F_PTR_WIDTH = 4,
    parameter int FWFT        = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    sync_fifo_prog_if.slave   bus
);
    localparam int                   PW1     = F_PTR_WIDTH + 1;
    localparam logic [F_PTR_WIDTH:0] DEPTH_V = PW1'(F_DEPTH);
    localparam logic [F_PTR_WIDTH:0] HALF_V  = PW1'(F_DEPTH / 2);
    localparam logic [F_PTR_WIDTH:0] ONE_V   = PW1'(1);

    logic [F_WIDTH-1:0]   mem_q [F_DEPTH];
    logic [F_PTR_WIDTH:0] w_ptr_q, w_ptr_d;
    logic [F_PTR_WIDTH:0] r_ptr_q, r_ptr_d;
    logic [F_PTR_WIDTH:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 full, empty, wr_ok, rd_ok;
    logic [F_WIDTH-1:0]   rd_word;

    assign full    = (cnt_q == DEPTH_V);
    assign empty   = (cnt_q == '0);
    // A pop frees a slot in the same cycle, so a full FIFO can still accept a write.
    assign rd_ok   = bus.r_en & ~empty;
    assign wr_ok   = bus.w_en & (~full | rd_ok);
    assign rd_word = mem_q[r_ptr_q[F_PTR_WIDTH-1:0]];

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (bus.clr) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            if (wr_ok) w_ptr_d = w_ptr_q + ONE_V;
            if (rd_ok) r_ptr_d = r_ptr_q + ONE_V;
            case ({wr_ok, rd_ok})
                2'b10:   cnt_d = cnt_q + ONE_V;
                2'b01:   cnt_d = cnt_q - ONE_V;
                default: cnt_d = cnt_q;
            endcase
            if (bus.w_en & full & ~rd_ok) ovf_d = 1'b1;
            if (bus.r_en & empty)         unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is not reset; a flush discards the write of that cycle.
    always_ff @(posedge clk) begin
        if (wr_ok && !bus.clr) mem_q[w_ptr_q[F_PTR_WIDTH-1:0]] <= bus.d_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.d_out   = rd_word;
            assign bus.d_valid = ~empty;
        end else begin : g_std
            logic [F_WIDTH-1:0] dout_q, dout_d;
            logic               dvld_q, dvld_d;

            always_comb begin
                dout_d = dout_q;
                dvld_d = 1'b0;
                if (bus.clr) begin
                    dout_d = '0;
                end else if (rd_ok) begin
                    dout_d = rd_word;
                    dvld_d = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q <= '0;
                    dvld_q <= 1'b0;
                end else begin
                    dout_q <= dout_d;
                    dvld_q <= dvld_d;
                end
            end

            assign bus.d_out   = dout_q;
            assign bus.d_valid = dvld_q;
        end
    endgenerate

    assign bus.f_count             = cnt_q;
    assign bus.f_full_flag         = full;
    assign bus.f_empty_flag        = empty;
    assign bus.f_half_full_flag    = (cnt_q >= HALF_V);
    // Zero / >=depth thresholds pin the flags high through the plain compares.
    assign bus.f_almost_full_flag  = (cnt_q >= bus.af_thresh);
    assign bus.f_almost_empty_flag = (cnt_q <= bus.ae_thresh);
    assign bus.f_overflow          = ovf_q;
    assign bus.f_underflow         = unf_q;
endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
- Single-clock, fully parameterised FIFO; successor of the team's pointer-difference FIFO.
- Uses all F_DEPTH entries (extra pointer wrap bit) and exposes an occupancy count.
- Almost-full/almost-empty thresholds are runtime-programmable; adds a synchronous flush, sticky overflow/underflow error flags, and an optional first-word-fall-through (FWFT) read mode.
- Used as the local buffer between same-clock pipeline stages and in front of the dual-clock FIFO.

Parameters:
- F_WIDTH, 8, data word width in bits.
- F_DEPTH, 16, number of entries; must be a power of two, minimum 4.
- F_PTR_WIDTH, 4, log2(F_DEPTH); pointers are F_PTR_WIDTH+1 bits wide including the wrap bit.
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk, input, 1, single clock; all state changes on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- clr, input, 1, synchronous flush; empties the FIFO and clears the error flags.
- d_in, input, F_WIDTH, write data.
- w_en, input, 1, write request.
- r_en, input, 1, read request (pop).
- af_thresh, input, F_PTR_WIDTH+1, almost-full threshold.
- ae_thresh, input, F_PTR_WIDTH+1, almost-empty threshold.
- d_out, output, F_WIDTH, read data.
- d_valid, output, 1, d_out holds valid read data.
- f_count, output, F_PTR_WIDTH+1, current occupancy, 0..F_DEPTH.
- f_full_flag, output, 1, f_count == F_DEPTH.
- f_empty_flag, output, 1, f_count == 0.
- f_half_full_flag, output, 1, f_count >= F_DEPTH/2.
- f_almost_full_flag, output, 1, f_count >= af_thresh.
- f_almost_empty_flag, output, 1, f_count <= ae_thresh.
- f_overflow, output, 1, sticky: a write was attempted while full with no pop in the same cycle.
- f_underflow, output, 1, sticky: a read was attempted while empty.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - Pointers, f_count, f_overflow, f_underflow = 0; d_out = 0; d_valid = 0.
  - f_empty_flag = 1 and f_almost_empty_flag = 1 (when ae_thresh >= 0); all other flags 0.
  - Memory contents are not reset.
- clr: same effect as reset but synchronous, applied on the next posedge. It has priority over w_en/r_en in that cycle; any write or read in that cycle is discarded.
- Accept conditions, evaluated against registered state:
  - wr_ok = w_en & (!full | rd_ok).
  - rd_ok = r_en & !empty.
  - A write into a full FIFO is accepted if a read is accepted in the same cycle; f_count is unchanged.
  - A read from an empty FIFO is never accepted, even with a simultaneous write. The write still lands and f_count goes 0 -> 1.
- Pointers: w_ptr and r_ptr increment modulo 2^(F_PTR_WIDTH+1) on wr_ok and rd_ok respectively. Memory is addressed with the low F_PTR_WIDTH bits.
- f_count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- Flags: combinational from registered f_count, so they change in the cycle after the causing edge. There are no other pipeline delays.
- Standard mode (FWFT = 0):
  - On rd_ok, d_out <= mem[r_ptr] at the same edge; d_valid = 1 for exactly that following cycle.
  - Otherwise d_out holds its last value and d_valid = 0.
- FWFT mode (FWFT = 1):
  - d_out = mem[r_ptr[F_PTR_WIDTH-1:0]] combinationally; d_valid = !f_empty_flag.
  - r_en pops the word currently shown.
  - A word written into an empty FIFO appears on d_out, with d_valid = 1, one cycle after the write edge.
  - While empty, d_out is don't-care.
- Error flags:
  - f_overflow sets on w_en & full & !rd_ok.
  - f_underflow sets on r_en & empty.
  - Rejected operations leave pointers and memory untouched.
  - Both flags clear only on reset or clr.
- Thresholds: af_thresh/ae_thresh are sampled continuously and may change at any time; the flags follow combinationally.
  - af_thresh = 0 forces almost_full to 1.
  - ae_thresh >= F_DEPTH forces almost_empty to 1.
- Wrap-around: full and empty are distinguished by the wrap bit. After any number of wraps, f_count must equal (w_ptr - r_ptr) mod 2^(F_PTR_WIDTH+1).

Test Plan:
- Reset, then 16 writes of 0x00..0x0F with no reads: after the last edge f_count = 16, full = 1, half_full = 1, almost_full = 1 (af_thresh = 14). A 17th write sets f_overflow = 1, and f_count stays 16.
- From full, 16 reads in standard mode: d_out = 0x00..0x0F in order, each with d_valid = 1 on the cycle after its r_en. Then empty = 1, and a further r_en sets f_underflow = 1 with d_out held at 0x0F.
- Simultaneous w_en and r_en while full (value 0xA5): f_count stays 16, f_overflow stays 0, and 0xA5 is read out last after the 15 older words.
- FWFT = 1: write 0x3C into the empty FIFO; the next cycle d_out = 0x3C and d_valid = 1 with no r_en. Pulse r_en: d_valid = 0 and empty = 1 the following cycle.
- Run 40 mixed write/read cycles (pointers wrap twice) with ae_thresh = 2 and af_thresh = 12: check f_count against a scoreboard every cycle; almost_empty asserts at count <= 2 and almost_full at count >= 12.
- With 5 entries and f_overflow = 1, assert clr together with w_en: the next cycle f_count = 0, empty = 1 and f_overflow = 0. Deassert rst_n mid-burst: all outputs reach their reset values with no clock edge.
